// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single-port data memory between the CPU MEM
// stage (port 0) and a debug/loader port (port 1). Each access runs as a
// fixed latch -> access -> acknowledge sequence. Out-of-range and misaligned
// accesses complete with err set, and their writes are suppressed.
//
// Handshake: a requester raises reqN and holds its fields stable until it
// sees ackN. ackN is a one-cycle pulse in DONE. The requester must drop or
// renew reqN at the edge that ends DONE, because IDLE samples req afresh.
// rdataN is valid with ackN and holds until the next ack to that port.
module dm_port_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int ADDR_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic        b0,
  input  logic        b1,
  input  logic        ext0,
  input  logic        ext1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  output logic        dm_we,
  output logic        dm_b,
  output logic        dm_ext,
  input  logic [31:0] dm_dout,
  output logic        busy,
  output logic        gnt_id,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [31:0] WORDS_L = 32'(ADDR_WORDS);

  state_t      state;
  logic        last_gnt;
  logic        we_l;
  logic        bad;

  logic        pick;
  logic        any_req;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_we;
  logic        sel_b;
  logic        sel_ext;
  logic        sel_bad;

  assign dbg_state = state;

  // Grant decision and mux of the winning port's fields for the IDLE latch
  always_comb begin
    any_req = req0 | req1;
    pick    = 1'b0;
    if (req0 && req1) begin
      pick = FIXED_PRIO ? 1'b0 : ~last_gnt;
    end else begin
      pick = req1;
    end
    sel_addr  = pick ? addr1  : addr0;
    sel_wdata = pick ? wdata1 : wdata0;
    sel_we    = pick ? we1    : we0;
    sel_b     = pick ? b1     : b0;
    sel_ext   = pick ? ext1   : ext0;
    sel_bad   = ({2'b00, sel_addr[31:2]} >= WORDS_L) |
                (~sel_b & (sel_addr[1:0] != 2'b00));
  end

  // Write strobe only in BUSY; reset kills an in-flight write immediately
  assign dm_we = (state == S_BUSY) & we_l & ~bad & ~rst;

  // Transaction sequencer with registered ack/err/rdata and dm_* fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      last_gnt <= 1'b1;
      gnt_id   <= 1'b0;
      we_l     <= 1'b0;
      bad      <= 1'b0;
      busy     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      rdata0   <= 32'h0;
      rdata1   <= 32'h0;
      dm_addr  <= 32'h0;
      dm_din   <= 32'h0;
      dm_b     <= 1'b0;
      dm_ext   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            dm_addr  <= sel_addr;
            dm_din   <= sel_wdata;
            dm_b     <= sel_b;
            dm_ext   <= sel_ext;
            we_l     <= sel_we;
            bad      <= sel_bad;
            gnt_id   <= pick;
            last_gnt <= pick;
            busy     <= 1'b1;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Stores also capture dout, which reflects the negedge write
          if (gnt_id) begin
            rdata1 <= bad ? 32'h0 : dm_dout;
            ack1   <= 1'b1;
            err1   <= bad;
          end else begin
            rdata0 <= bad ? 32'h0 : dm_dout;
            ack0   <= 1'b1;
            err0   <= bad;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          err0  <= 1'b0;
          err1  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Two-requester arbiter and sequencer for the single-port data memory (`dm`). It shares `dm` between a primary requester (port 0, CPU MEM stage) and a secondary requester (port 1, debug/loader), and runs each access as a fixed 3-state transaction: latch, access, acknowledge. It detects out-of-range and misaligned accesses and suppresses their writes. Its `dm_*` outputs drive the `dm` instance directly.

## Interface
- `FIXED_PRIO`, 0: 0 = round-robin between ports; 1 = port 0 always wins.
- `ADDR_WORDS`, 128: number of 32-bit words in `dm`. Word index `addr[31:2] >= ADDR_WORDS` is out of range.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req0` / `req1` in 1: access request; held high with fields stable until `ack` is seen.
- `we0` / `we1` in 1: 1 = store, 0 = load.
- `b0` / `b1` in 1: byte access (maps to `dm.B`).
- `ext0` / `ext1` in 1: sign-extend byte load (maps to `dm.ExtOp`).
- `addr0` / `addr1` in 32: byte address.
- `wdata0` / `wdata1` in 32: store data; byte stores use `[7:0]`.
- `ack0` / `ack1` out 1: one-cycle completion pulse.
- `rdata0` / `rdata1` out 32: load result, valid while `ack` is high and held until the next ack to that port.
- `err0` / `err1` out 1: pulses with `ack` when the access was rejected.
- `dm_addr` out 32: to `dm.addr`.
- `dm_din` out 32: to `dm.din`.
- `dm_we` out 1: to `dm.we`.
- `dm_b` out 1: to `dm.B`.
- `dm_ext` out 1: to `dm.ExtOp`.
- `dm_dout` in 32: from `dm.dout`.
- `busy` out 1: high in BUSY and DONE.
- `gnt_id` out 1: port that owns the current or last transaction.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - If neither req is high: stay in IDLE.
  - If one req is high: grant that port.
  - If both are high and `FIXED_PRIO=1`: grant port 0.
  - If both are high and `FIXED_PRIO=0`: grant the port that is not `last_gnt`.
  - On grant: latch that port's addr, wdata, we, b and ext into the `dm_*` registers, set `gnt_id` and `last_gnt`, and compute the `bad` flag. Go to BUSY.
- **bad flag**: `bad = (addr[31:2] >= ADDR_WORDS) | (!b & addr[1:0] != 0)`.
- **BUSY**
  - `dm_we = we_l & !bad & !rst` (combinational). The `dm` write lands on the negedge inside BUSY.
  - At the posedge ending BUSY, `rdata<gnt_id>` <= `bad ? 0 : dm_dout`.
  - Stores also update `rdata`, with the value `dm` presents at that posedge.
  - Go to DONE.
- **DONE**
  - `ack<gnt_id>` = 1 and `err<gnt_id>` = `bad`.
  - The other port's ack and err stay 0.
  - Next state is IDLE unconditionally.
- `dm_we` is 0 in every state except BUSY.
- The `dm_*` address and data registers hold their last value while IDLE.
- The requester must drop or renew `req` at the posedge ending DONE. IDLE then samples the fresh value, so an access is never issued twice.
- A request arriving during BUSY or DONE waits, with no loss, until IDLE.
- `last_gnt` is updated only on a grant. Under `FIXED_PRIO=1` it is tracked but ignored.
- **Reset (any state)**, at the next posedge:
  - state = IDLE; `last_gnt` = 1, so port 0 wins the first tie.
  - `gnt_id`, ack*, err*, rdata*, `dm_addr`, `dm_din`, `dm_b` and `dm_ext` all = 0.
  - `busy` = 0, `dm_we` = 0.
  - Because `dm_we` is gated by `!rst`, a reset asserted during BUSY suppresses that cycle's write. The in-flight transaction is dropped and no ack is issued.

## Timing
- Grant to ack: req sampled high in IDLE at edge N gives BUSY in cycle N+1 and `ack` in cycle N+2.
- Throughput: 1 access per 3 cycles.
- Back-to-back under contention in round-robin mode: grants alternate, giving 6 cycles per pair.
- `ack`, `err` and `rdata` are registered. `dm_we` is the only combinational output.

## Test plan
- **Reset.** Hold `rst` for 2 cycles while `req0=1`.
  - Required: all outputs 0 and no ack during reset.
  - Then release `rst`: the first `ack0` arrives 2 cycles after the first IDLE sample.
- **Store then load, port 0.**
  - Store 0xDEADBEEF to addr 0x10: `dm_we` is high for exactly one cycle and `ack0` pulses with `err0=0`.
  - Then load addr 0x10: `rdata0 = 0xDEADBEEF`.
- **Byte store and signed load, port 1.**
  - Store byte 0x80 to addr 0x11 (b=1).
  - Load addr 0x11 with b=1, ext=1: `rdata1 = 0xFFFFFF80`.
  - With ext=0: `rdata1 = 0x00000080`.
  - Word at 0x10 reads 0xDEAD80EF.
- **Contention, round-robin.** Hold `req0` and `req1` high for 12 cycles.
  - Acks alternate 0, 1, 0, 1, with one ack every 3 cycles.
  - With `FIXED_PRIO=1`, only `ack0` fires.
- **Rejected accesses.**
  - Word store to addr 0x202 (misaligned): `dm_we` stays 0 and `err0`=1 with `ack0`.
  - Store to word index 128 (addr 0x200): same response, `dm_we` stays 0 and `err0`=1.
  - A following load of the original locations is unchanged.
- **Reset mid-transaction.** Assert `rst` during the BUSY cycle of a store to 0x20.
  - Required: no `ack`, mem[0x20] is unchanged, and the FSM is back in IDLE on the next cycle.
